// File: rtl/mem_stage_pkg.sv
// Shared types for the memory stage: op-code fields, length codes,
// FSM state encoding and the load-extension helper.
package mem_stage_pkg;

  localparam int ME_EN     = 4;
  localparam int ME_LEN_HI = 3;
  localparam int ME_LEN_LO = 2;
  localparam int ME_WR     = 1;
  localparam int ME_ZX     = 0;

  // Index of the last byte of an access.
  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd3;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic [1:0]  last;
    logic        wr;
    logic        zext;
    logic [31:0] data;
    logic [4:0]  wa;
    logic        we;
  } mem_op_t;

  // Length code 2 is reserved and behaves as a word.
  function automatic logic [1:0] len_last(
    input logic [1:0] code
  );
    logic [1:0] r;
    unique case (code)
      2'd0:    r = LEN_B;
      2'd1:    r = LEN_H;
      default: r = LEN_W;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ld_extend(
    input logic [31:0] d,
    input logic [1:0]  last,
    input logic        zext
  );
    logic [31:0] r;
    unique case (last)
      LEN_B: begin
        r = zext ? {24'd0, d[7:0]}
                 : {{24{d[7]}}, d[7:0]};
      end
      LEN_H: begin
        r = zext ? {16'd0, d[15:0]}
                 : {{16{d[15]}}, d[15:0]};
      end
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// Byte counter plus req/ack handshake for byte-serial accesses.
// Ports: start, last index, ack in; req, byte idx, done (final ack) out.
module mem_byte_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [1:0] last,
  input  logic       ack,
  output logic       req,
  output logic [1:0] idx,
  output logic       done
);

  logic       req_q;
  logic [1:0] idx_q;

  // Ack without an outstanding request is ignored.
  assign done = req_q & ack & (idx_q == last);
  assign req  = req_q;
  assign idx  = idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= 1'b0;
      idx_q <= 2'd0;
    end else if (start) begin
      req_q <= 1'b1;
      idx_q <= 2'd0;
    end else if (done) begin
      req_q <= 1'b0;
      idx_q <= 2'd0;
    end else if (req_q & ack) begin
      idx_q <= idx_q + 2'd1;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: byte-serial little-endian loads/stores on an 8-bit port,
// load extension, registered writeback packet, stall while busy.
// Ports: execute packet in (valid_i,res_i,wa_i,we_i,mem_e_i,mem_n_i),
// writeback out (valid_o,wa_o,we_o,wdata_o), stall_o, mc_* byte port.
// MEM_ALIGN_CHECK_EN: reject misaligned half/word, adds misalign_o.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [31:0]       res_i,
  input  logic [4:0]        wa_i,
  input  logic              we_i,
  input  logic [4:0]        mem_e_i,
  input  logic [31:0]       mem_n_i,
  output logic              stall_o,
  output logic              valid_o,
  output logic [4:0]        wa_o,
  output logic              we_o,
  output logic [31:0]       wdata_o,
`ifdef MEM_ALIGN_CHECK_EN
  output logic              misalign_o,
`endif
  output logic              mc_req_o,
  output logic [ADDR_W-1:0] mc_addr_o,
  output logic              mc_we_o,
  output logic [7:0]        mc_wdata_o,
  input  logic              mc_ack_i,
  input  logic [7:0]        mc_rdata_i
);

  mem_state_e        state_q;
  mem_state_e        state_d;
  mem_op_t           op_q;
  logic [ADDR_W-1:0] base_q;
  logic [31:0]       ld_q;
  logic [31:0]       ld_next;
  logic [1:0]        idx;
  logic              seq_req;
  logic              seq_done;
  logic              mem_en;
  logic              misal;
  logic              accept;
  logic [1:0]        len;

  assign len    = len_last(mem_e_i[ME_LEN_HI:ME_LEN_LO]);
  assign mem_en = valid_i & mem_e_i[ME_EN];

`ifdef MEM_ALIGN_CHECK_EN
  assign misal = mem_en &
    (((len == LEN_H) & res_i[0]) |
     ((len == LEN_W) & (|res_i[1:0])));
`else
  assign misal = 1'b0;
`endif

  assign accept = (state_q == IDLE) & mem_en & ~misal;

  mem_byte_seq u_seq (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept),
    .last  (op_q.last),
    .ack   (mc_ack_i),
    .req   (seq_req),
    .idx   (idx),
    .done  (seq_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (accept)   state_d = ACCESS;
      ACCESS: if (seq_done) state_d = IDLE;
    endcase
  end

  // Releasing stall on the final ack lets upstream advance so IDLE
  // sees the next packet one cycle later.
  always_comb begin
    stall_o = 1'b0;
    unique case (state_q)
      IDLE:   stall_o = accept;
      ACCESS: stall_o = ~seq_done;
    endcase
  end

  assign mc_req_o   = seq_req;
  assign mc_we_o    = seq_req & op_q.wr;
  assign mc_addr_o  = seq_req ? base_q + ADDR_W'(idx) : '0;
  assign mc_wdata_o = seq_req ? op_q.data[{idx, 3'b000} +: 8] : 8'd0;

  always_comb begin
    ld_next = ld_q;
    ld_next[{idx, 3'b000} +: 8] = mc_rdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_o <= 1'b0;
      wa_o    <= 5'd0;
      we_o    <= 1'b0;
      wdata_o <= 32'd0;
      op_q    <= '0;
      base_q  <= '0;
      ld_q    <= 32'd0;
`ifdef MEM_ALIGN_CHECK_EN
      misalign_o <= 1'b0;
`endif
    end else begin
`ifdef MEM_ALIGN_CHECK_EN
      misalign_o <= 1'b0;
`endif
      unique case (state_q)
        IDLE: begin
          valid_o <= valid_i & (~mem_e_i[ME_EN] | misal);
          if (valid_i & ~mem_e_i[ME_EN]) begin
            wa_o    <= wa_i;
            we_o    <= we_i;
            wdata_o <= res_i;
          end
          if (misal) begin
            wa_o    <= wa_i;
            we_o    <= 1'b0;
            wdata_o <= 32'd0;
`ifdef MEM_ALIGN_CHECK_EN
            misalign_o <= 1'b1;
`endif
          end
          if (accept) begin
            op_q.last <= len;
            op_q.wr   <= mem_e_i[ME_WR];
            op_q.zext <= mem_e_i[ME_ZX];
            op_q.data <= mem_n_i;
            op_q.wa   <= wa_i;
            op_q.we   <= we_i;
            base_q    <= res_i[ADDR_W-1:0];
            ld_q      <= 32'd0;
          end
        end
        ACCESS: begin
          valid_o <= seq_done;
          if (seq_req & mc_ack_i) ld_q <= ld_next;
          if (seq_done) begin
            wa_o    <= op_q.wa;
            we_o    <= op_q.we;
            wdata_o <= op_q.wr ? 32'd0
                     : ld_extend(ld_next, op_q.last, op_q.zext);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a byte-wide memory responder
// whose ack delay is programmable.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_i;
  logic [31:0] res_i;
  logic [4:0]  wa_i;
  logic        we_i;
  logic [4:0]  mem_e_i;
  logic [31:0] mem_n_i;
  logic        stall_o;
  logic        valid_o;
  logic [4:0]  wa_o;
  logic        we_o;
  logic [31:0] wdata_o;
  logic        mc_req_o;
  logic [31:0] mc_addr_o;
  logic        mc_we_o;
  logic [7:0]  mc_wdata_o;
  logic        mc_ack_i;
  logic [7:0]  mc_rdata_i;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misalign_o;
`endif

  int checks = 0;
  int errors = 0;
  int ack_dly = 0;
  int wcnt = 0;
  int nwr = 0;
  logic [7:0] wmem [256];

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_i    (valid_i),
    .res_i      (res_i),
    .wa_i       (wa_i),
    .we_i       (we_i),
    .mem_e_i    (mem_e_i),
    .mem_n_i    (mem_n_i),
    .stall_o    (stall_o),
    .valid_o    (valid_o),
    .wa_o       (wa_o),
    .we_o       (we_o),
    .wdata_o    (wdata_o),
`ifdef MEM_ALIGN_CHECK_EN
    .misalign_o (misalign_o),
`endif
    .mc_req_o   (mc_req_o),
    .mc_addr_o  (mc_addr_o),
    .mc_we_o    (mc_we_o),
    .mc_wdata_o (mc_wdata_o),
    .mc_ack_i   (mc_ack_i),
    .mc_rdata_i (mc_rdata_i)
  );

  function automatic logic [7:0] rom(input logic [7:0] a);
    logic [7:0] r;
    case (a)
      8'h00:   r = 8'h78;
      8'h01:   r = 8'h56;
      8'h02:   r = 8'h34;
      8'h03:   r = 8'h12;
      8'h20:   r = 8'h80;
      8'hFF:   r = 8'h9A;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (mc_req_o && mc_ack_i) begin
      if (mc_we_o) begin
        wmem[mc_addr_o[7:0]] <= mc_wdata_o;
        nwr <= nwr + 1;
      end
      wcnt <= 0;
    end else if (mc_req_o) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
    end
    #2;
    if (mc_req_o && wcnt == ack_dly) begin
      mc_ack_i   = 1'b1;
      mc_rdata_i = rom(mc_addr_o[7:0]);
    end else begin
      mc_ack_i   = 1'b0;
      mc_rdata_i = 8'h00;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] res,
                       input logic [4:0] wa,
                       input logic we,
                       input logic [4:0] me,
                       input logic [31:0] n);
    valid_i = 1'b1;
    res_i   = res;
    wa_i    = wa;
    we_i    = we;
    mem_e_i = me;
    mem_n_i = n;
  endtask

  task automatic load(input string tag,
                      input logic [31:0] addr,
                      input logic [4:0] me,
                      input int nb,
                      input logic [31:0] exp);
    cyc();
    drive(addr, 5'd7, 1'b1, me, 32'd0);
    mid();
    chk({tag, "_stall0"}, 32'(stall_o), 32'd1);
    for (int k = 0; k < nb; k++) begin
      cyc();
      valid_i = 1'b0;
      mid();
      chk({tag, "_req"}, 32'(mc_req_o), 32'd1);
      chk({tag, "_addr"}, mc_addr_o, addr + 32'(k));
      chk({tag, "_stall"}, 32'(stall_o), (k == nb - 1) ? 32'd0 : 32'd1);
    end
    cyc();
    mid();
    chk({tag, "_valid"}, 32'(valid_o), 32'd1);
    chk({tag, "_wdata"}, wdata_o, exp);
    chk({tag, "_reqlo"}, 32'(mc_req_o), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n   = 1'b0;
    valid_i = 1'b0;
    res_i   = 32'd0;
    wa_i    = 5'd0;
    we_i    = 1'b0;
    mem_e_i = 5'd0;
    mem_n_i = 32'd0;
    repeat (2) @(posedge clk);
    mid();
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_req", 32'(mc_req_o), 32'd0);
    chk("rst_wdata", wdata_o, 32'd0);
    rst_n = 1'b1;

    // ALU pass-through
    cyc();
    drive(32'h1234, 5'd5, 1'b1, 5'h00, 32'd0);
    mid();
    chk("alu_stall", 32'(stall_o), 32'd0);
    cyc();
    valid_i = 1'b0;
    mid();
    chk("alu_valid", 32'(valid_o), 32'd1);
    chk("alu_wdata", wdata_o, 32'h1234);
    chk("alu_wa", 32'(wa_o), 32'd5);
    chk("alu_we", 32'(we_o), 32'd1);
    chk("alu_req", 32'(mc_req_o), 32'd0);
    cyc();
    mid();
    chk("idle_valid", 32'(valid_o), 32'd0);

    load("lw", 32'h100, 5'h1C, 4, 32'h12345678);
    chk("lw_wa", 32'(wa_o), 32'd7);
    load("lb", 32'h20, 5'h10, 1, 32'hFFFFFF80);
    load("lbu", 32'h20, 5'h11, 1, 32'h00000080);
    load("len2", 32'h100, 5'h18, 4, 32'h12345678);
`ifndef MEM_ALIGN_CHECK_EN
    load("lhwrap", 32'hFFFFFFFF, 5'h14, 2, 32'h0000789A);
`endif

    // SH with three wait cycles per byte
    ack_dly = 3;
    cyc();
    drive(32'h40, 5'd3, 1'b0, 5'h16, 32'hDEADA1B2);
    mid();
    chk("sh_stall0", 32'(stall_o), 32'd1);
    for (int c = 1; c <= 8; c++) begin
      cyc();
      valid_i = 1'b0;
      mem_n_i = 32'h5555_5555;
      mid();
      chk("sh_req", 32'(mc_req_o), 32'd1);
      chk("sh_we", 32'(mc_we_o), 32'd1);
      chk("sh_addr", mc_addr_o, (c <= 4) ? 32'h40 : 32'h41);
      chk("sh_byte", 32'(mc_wdata_o), (c <= 4) ? 32'hB2 : 32'hA1);
      chk("sh_stall", 32'(stall_o), (c == 8) ? 32'd0 : 32'd1);
    end
    cyc();
    mid();
    chk("sh_valid", 32'(valid_o), 32'd1);
    chk("sh_wdata", wdata_o, 32'd0);
    chk("sh_wbwe", 32'(we_o), 32'd0);
    chk("sh_reqlo", 32'(mc_req_o), 32'd0);
    chk("sh_m40", 32'(wmem[8'h40]), 32'hB2);
    chk("sh_m41", 32'(wmem[8'h41]), 32'hA1);
    chk("sh_nwr", 32'(nwr), 32'd2);

    // SW aborted by reset during its third byte
    ack_dly = 1;
    cyc();
    drive(32'h60, 5'd0, 1'b0, 5'h1E, 32'h11223344);
    for (int c = 1; c <= 5; c++) begin
      cyc();
      valid_i = 1'b0;
    end
    mid();
    chk("sw_addr2", mc_addr_o, 32'h62);
    rst_n = 1'b0;
    #1;
    chk("sw_rst_req", 32'(mc_req_o), 32'd0);
    chk("sw_rst_stall", 32'(stall_o), 32'd0);
    chk("sw_rst_valid", 32'(valid_o), 32'd0);
    chk("sw_m60", 32'(wmem[8'h60]), 32'h44);
    chk("sw_m61", 32'(wmem[8'h61]), 32'h33);
    chk("sw_nwr", 32'(nwr), 32'd4);
    cyc();
    mid();
    rst_n = 1'b1;
    ack_dly = 0;
    cyc();
    drive(32'hCAFE, 5'd9, 1'b1, 5'h00, 32'd0);
    cyc();
    valid_i = 1'b0;
    mid();
    chk("post_valid", 32'(valid_o), 32'd1);
    chk("post_wdata", wdata_o, 32'hCAFE);
    chk("post_wa", 32'(wa_o), 32'd9);
    chk("post_nwr", 32'(nwr), 32'd4);

`ifdef MEM_ALIGN_CHECK_EN
    cyc();
    drive(32'h102, 5'd4, 1'b1, 5'h1C, 32'd0);
    mid();
    chk("mis_stall", 32'(stall_o), 32'd0);
    cyc();
    valid_i = 1'b0;
    mid();
    chk("mis_req", 32'(mc_req_o), 32'd0);
    chk("mis_valid", 32'(valid_o), 32'd1);
    chk("mis_we", 32'(we_o), 32'd0);
    chk("mis_pulse", 32'(misalign_o), 32'd1);
    cyc();
    mid();
    chk("mis_pulse_end", 32'(misalign_o), 32'd0);
    chk("mis_req2", 32'(mc_req_o), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
